nonce_uart_tx: RTL

Serial result transmitter for the miner core: takes 32-bit golden nonces from the hashing pipeline and sends each one out on `TxD` as four 8N1 UART bytes, least-significant byte first. It is the transmit counterpart of the work-receive path on `RxD`. It sits between the nonce-match logic and the `TxD` pin and carries a small FIFO, so nonces found close together are queued rather than lost.

---
 rtl/nonce_uart_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/nonce_uart_tx.sv
// Golden-nonce transmitter: queues 32-bit nonces in a small FIFO and sends each one on TxD
// as four 8N1 bytes, least-significant byte first.
module nonce_uart_tx #(
    parameter int SPEED_MHZ  = 50,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 nonce_in,
    input  logic                        nonce_valid,
    output logic                        nonce_ready,
    output logic                        TxD,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int CLKS_PER_BIT = (SPEED_MHZ * 1000000) / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = PTR_W + 1;

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("nonce_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (1 << PTR_W) != FIFO_DEPTH) begin : g_bad_depth
        $error("nonce_uart_tx: FIFO_DEPTH must be a power of two, at least 2");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             wr_en, pop;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             txd_q, txd_d;
    logic             bit_end;
    logic [7:0]       cur_byte;

    assign nonce_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign wr_en       = nonce_valid && nonce_ready;
    assign pop         = (state_q == ST_IDLE) && (level_q != '0);
    assign bit_end     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign cur_byte    = shreg_q[7:0];

    assign TxD   = txd_q;
    assign level = level_q;
    assign busy  = (state_q != ST_IDLE) || (level_q != '0);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= nonce_in;
        end
    end

    // Write and pop at the same edge both take effect; level nets out unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        txd_d   = txd_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
                if (pop) begin
                    shreg_d = mem[rd_ptr_q];
                    byte_d  = 2'd0;
                    txd_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = 3'd0;
                    txd_d   = cur_byte[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = cur_byte[bit_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Next byte's start bit follows the stop bit with no idle gap.
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shreg_d = {8'h00, shreg_q[31:8]};
                        txd_d   = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            txd_q   <= txd_d;
        end
    end

endmodule
